leg_reg_bank: RTL and testbench

- Register bank for the LEG core. It sits directly upstream of the 8-way operand-select muxes and drives all eight of their 8-bit inputs.
- Slots 0-5 are general-purpose registers, slot 6 is the program counter, and slot 7 is the I/O port.
- It owns the PC increment/jump logic and the ready/valid handshakes for the input and output ports.
- It is instantiated once in the core; the two operand muxes read all eight slots from it in parallel.

---
 rtl/leg_pkg.sv | 8 +
 rtl/leg_io_buffer.sv | 24 ++
 rtl/leg_reg_bank.sv | 84 ++++++++
 tb/tb_leg_reg_bank.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/leg_pkg.sv
// leg_pkg: shared widths and slot constants for the LEG register bank
package leg_pkg;
  localparam int WORD_W = 8;
  localparam logic [2:0] REG_PC = 3'd6;
  localparam logic [2:0] REG_IO = 3'd7;
  localparam logic [WORD_W-1:0] PC_STEP = 8'd4;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/leg_io_buffer.sv
// leg_io_buffer: one-entry ready/valid holding register, loaded on load, cleared on pop
module leg_io_buffer
  import leg_pkg::*;
#(
  parameter int UUID = 0
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  pop,
  input  word_t din,
  output logic  full,
  output word_t dout
);
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      dout <= '0;
    end else begin
      full <= load | (full & ~pop);
      if (load) dout <= din;
    end
  end
endmodule

// File: rtl/leg_reg_bank.sv
// leg_reg_bank: GP registers, PC and I/O slot feeding the LEG operand muxes
module leg_reg_bank
  import leg_pkg::*;
#(
  parameter int          UUID     = 0,
  parameter string       NAME     = "",
  parameter logic [7:0]  PC_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       pc_inc,
  input  logic       jump_en,
  input  logic [7:0] jump_target,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       rd7_consume,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       stall,
  output logic [7:0] r0,
  output logic [7:0] r1,
  output logic [7:0] r2,
  output logic [7:0] r3,
  output logic [7:0] r4,
  output logic [7:0] r5,
  output logic [7:0] r6,
  output logic [7:0] r7
);
  word_t      gp [6];
  word_t      pc;
  word_t      in_buf;
  logic       in_full;
  logic [2:0] addr;
  logic       wr_pc;
  logic       wr_io;
  logic       unused_addr;
  assign addr        = wr_addr[2:0];
  assign unused_addr = ^wr_addr[7:3];
  assign wr_pc       = wr_en & (addr == REG_PC);
  assign wr_io       = wr_en & (addr == REG_IO);
  assign in_ready    = ~in_full | rd7_consume;
  assign stall       = (rd7_consume & ~in_full) | (wr_io & out_valid & ~out_ready);
  leg_io_buffer #(.UUID(UUID ^ 1)) u_in (
    .clk  (clk),
    .rst  (rst),
    .load (in_valid & in_ready),
    .pop  (rd7_consume),
    .din  (in_data),
    .full (in_full),
    .dout (in_buf)
  );
  // a held byte is replaced in the same edge it is accepted
  leg_io_buffer #(.UUID(UUID ^ 2)) u_out (
    .clk  (clk),
    .rst  (rst),
    .load (wr_io & (~out_valid | out_ready)),
    .pop  (out_ready),
    .din  (wr_data),
    .full (out_valid),
    .dout (out_data)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) gp[i] <= '0;
      pc <= PC_RESET;
    end else if (!stall) begin
      for (int i = 0; i < 6; i++) if (wr_en && addr == 3'(i)) gp[i] <= wr_data;
      pc <= wr_pc ? wr_data : jump_en ? jump_target : pc_inc ? pc + PC_STEP : pc;
    end
  end
  assign r0 = gp[0];
  assign r1 = gp[1];
  assign r2 = gp[2];
  assign r3 = gp[3];
  assign r4 = gp[4];
  assign r5 = gp[5];
  assign r6 = pc;
  assign r7 = in_full ? in_buf : '0;
endmodule

// File: tb/tb_leg_reg_bank.sv
// tb_leg_reg_bank: directed checks plus a per-cycle model comparison of leg_reg_bank
module tb_leg_reg_bank;
  logic       clk = 0, rst = 1, wr_en = 0, pc_inc = 0, jump_en = 0;
  logic       in_valid = 0, rd7_consume = 0, out_ready = 0;
  logic [7:0] wr_addr = 0, wr_data = 0, jump_target = 0, in_data = 0;
  logic       in_ready, out_valid, stall;
  logic [7:0] out_data, r0, r1, r2, r3, r4, r5, r6, r7;
  int tests = 0, fails = 0;
  logic       armed = 0;
  logic [7:0] m_reg [8];
  logic [7:0] m_in_q [$];
  logic [7:0] m_out_q [$];
  logic [7:0] m_out_data;
  logic [7:0] dr [8];

  leg_reg_bank #(.UUID(5), .NAME("tb"), .PC_RESET(8'h80)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pc_inc(pc_inc), .jump_en(jump_en), .jump_target(jump_target),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .rd7_consume(rd7_consume), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .stall(stall),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7)
  );

  always #5 clk = ~clk;
  assign dr = '{r0, r1, r2, r3, r4, r5, r6, r7};

  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic m_stall();
    return (rd7_consume && m_in_q.size() == 0) ||
           (wr_en && wr_addr[2:0] == 3'd7 && m_out_q.size() != 0 && !out_ready);
  endfunction

  function automatic logic m_in_ready();
    return m_in_q.size() == 0 || rd7_consume;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      armed = 1;
      for (int i = 0; i < 7; i++) m_reg[i] = 0;
      m_reg[6] = 8'h80;
      m_in_q.delete();
      m_out_q.delete();
      m_out_data = 0;
    end else begin
      automatic logic st = m_stall();
      automatic logic rdy = m_in_ready();
      automatic int a = int'(wr_addr[2:0]);
      if (!st) begin
        if (wr_en && a < 6) m_reg[a] = wr_data;
        if (wr_en && a == 6) m_reg[6] = wr_data;
        else if (jump_en) m_reg[6] = jump_target;
        else if (pc_inc) m_reg[6] = 8'((int'(m_reg[6]) + 4) % 256);
      end
      if (in_valid && rdy) begin
        m_in_q.delete();
        m_in_q.push_back(in_data);
      end else if (rd7_consume && m_in_q.size() != 0) m_in_q.pop_front();
      if (m_out_q.size() != 0 && out_ready) m_out_q.pop_front();
      if (wr_en && a == 7 && m_out_q.size() == 0) begin
        m_out_q.push_back(wr_data);
        m_out_data = wr_data;
      end
    end
  end

  always @(negedge clk) begin
    if (armed && !rst) begin
      for (int i = 0; i < 6; i++) chk($sformatf("model_r%0d", i), dr[i], m_reg[i]);
      chk("model_pc", r6, m_reg[6]);
      chk("model_r7", r7, m_in_q.size() != 0 ? m_in_q[0] : 8'h00);
      chk("model_in_ready", {7'd0, in_ready}, {7'd0, m_in_ready()});
      chk("model_out_valid", {7'd0, out_valid}, {7'd0, m_out_q.size() != 0});
      chk("model_out_data", out_data, m_out_data);
      chk("model_stall", {7'd0, stall}, {7'd0, m_stall()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    wr_en = 0; pc_inc = 0; jump_en = 0; in_valid = 0; rd7_consume = 0; out_ready = 0;
  endtask

  initial begin
    tick(); tick();
    rst = 0;
    tick();
    chk("rst_r0", r0, 8'h00);
    chk("rst_r5", r5, 8'h00);
    chk("rst_pc", r6, 8'h80);
    chk("rst_r7", r7, 8'h00);
    chk("rst_out_valid", {7'd0, out_valid}, 8'h00);
    chk("rst_in_ready", {7'd0, in_ready}, 8'h01);
    wr_en = 1; wr_addr = 8'h03; wr_data = 8'h5A;
    tick();
    chk("gp_write_r3", r3, 8'h5A);
    wr_addr = 8'hFB; wr_data = 8'h3C;
    tick();
    chk("gp_alias_r3", r3, 8'h3C);
    wr_addr = 8'h06; wr_data = 8'hFC;
    tick();
    wr_en = 0; pc_inc = 1;
    tick();
    chk("pc_wrap", r6, 8'h00);
    jump_en = 1; jump_target = 8'h40;
    tick();
    chk("pc_jump_over_inc", r6, 8'h40);
    wr_en = 1; wr_addr = 8'h06; wr_data = 8'h10;
    tick();
    chk("pc_write_over_jump", r6, 8'h10);
    idle();
    in_valid = 1; in_data = 8'h21;
    tick();
    chk("in_load", r7, 8'h21);
    in_data = 8'h22;
    #1 chk("in_ready_full", {7'd0, in_ready}, 8'h00);
    tick();
    chk("in_held_off", r7, 8'h21);
    rd7_consume = 1;
    tick();
    chk("in_replace", r7, 8'h22);
    in_valid = 0;
    tick();
    chk("in_consume_empty", r7, 8'h00);
    pc_inc = 1; wr_en = 1; wr_addr = 8'h02; wr_data = 8'hEE;
    #1 chk("stall_rd7_empty", {7'd0, stall}, 8'h01);
    tick();
    chk("stall_pc_hold", r6, 8'h10);
    chk("stall_gp_hold", r2, 8'h00);
    idle();
    wr_en = 1; wr_addr = 8'h07; wr_data = 8'h99;
    tick();
    chk("out_valid_set", {7'd0, out_valid}, 8'h01);
    chk("out_data_99", out_data, 8'h99);
    chk("out_r7_unchanged", r7, 8'h00);
    wr_data = 8'h77;
    #1 chk("stall_out_full", {7'd0, stall}, 8'h01);
    tick();
    chk("out_data_held", out_data, 8'h99);
    out_ready = 1;
    #1 chk("no_stall_ready", {7'd0, stall}, 8'h00);
    tick();
    chk("out_data_77", out_data, 8'h77);
    chk("out_valid_77", {7'd0, out_valid}, 8'h01);
    wr_en = 0;
    tick();
    chk("out_drained", {7'd0, out_valid}, 8'h00);
    idle();
    wr_en = 1; wr_addr = 8'h07; wr_data = 8'h55; in_valid = 1; in_data = 8'h33; pc_inc = 1;
    tick();
    idle();
    #1 chk("pre_rst_out_valid", {7'd0, out_valid}, 8'h01);
    chk("pre_rst_r7", r7, 8'h33);
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_out_valid", {7'd0, out_valid}, 8'h00);
    chk("mid_rst_r7", r7, 8'h00);
    chk("mid_rst_pc", r6, 8'h80);
    chk("mid_rst_out_data", out_data, 8'h00);
    for (int i = 0; i < 60; i++) begin
      wr_en = 1'($urandom_range(0, 1)); wr_addr = 8'($urandom);
      wr_data = 8'($urandom); pc_inc = 1'($urandom_range(0, 1));
      jump_en = 1'($urandom_range(0, 3) == 0); jump_target = 8'($urandom);
      in_valid = 1'($urandom_range(0, 1)); in_data = 8'($urandom);
      rd7_consume = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    idle();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
